aidc_lite_comp_cfg_mc: RTL and testbench
========================================

Name: aidc_lite_comp_cfg_mc

Overview:
- Multi-channel APB configuration and status block for the AIDC-Lite compression engines.
- Generalises the single-channel config block: NUM_CH independent register banks (src/dst/len), per-channel start pulse and busy tracking, sticky done/error status with write-1-to-clear, per-channel interrupt enables and a combined interrupt.
- Sits between the APB fabric and NUM_CH compressor channels.

Parameters:
- NUM_CH, 4, number of channels; legal range 1..32.
- LEN_LSB, 7, LSB of the length field; low LEN_LSB bits are forced to 0, so length granularity is 2^LEN_LSB bytes.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- apb_if  APB_INTF.slave  –  APB target: psel, penable, pwrite, paddr[31:0], pwdata[31:0], prdata[31:0], pready, pslverr
- src_addr_o  output  NUM_CH*32  per-channel source address; channel c occupies bits [32c+31:32c]
- dst_addr_o  output  NUM_CH*32  per-channel destination address, packed the same way
- len_o  output  NUM_CH*(32-LEN_LSB)  per-channel length[31:LEN_LSB], packed
- start_o  output  NUM_CH  one-cycle start pulse per channel
- done_i  input  NUM_CH  per-channel engine done level
- irq_o  output  1  level interrupt; OR over all channels of (done & irq_en)

Behaviour:
- Address decode:
  - Channel ch = paddr[9:5]; register reg = paddr[4:2].
  - Channel bank stride is 0x20.
- Per-channel register map:
  - 0x00 SRC (RW).
  - 0x04 DST (RW).
  - 0x08 LEN (RW); bits [LEN_LSB-1:0] read 0.
  - 0x0C CMD (WO); bit0=1 requests start; reads 0.
  - 0x10 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 err (W1C).
  - 0x14 IRQ_EN (RW, bit0).
- Decode errors: ch >= NUM_CH or reg in 6..7 → write ignored, read returns 0, pslverr=1.
- APB timing:
  - pready is tied to 1.
  - Writes take effect on the clock edge ending the access phase (psel & penable & pwrite).
  - Read data is registered during the setup phase (psel & ~penable & ~pwrite) and is valid throughout the access phase.
  - pslverr is combinational and asserted only during the access phase (psel & penable).
- Reset: every register, busy/done/err, start_o, prdata and irq_o are 0.
- Start:
  - A CMD write with bit0=1 while busy=0 → start_o[ch]=1 in the cycle after the access edge, for exactly one cycle; busy=1 in the same cycle.
  - A CMD write with bit0=1 while busy=1 → no pulse, err sets, pslverr=1.
- Writes to SRC, DST, LEN or IRQ_EN while busy=1 are ignored and give pslverr=1. Config is stable for the whole run.
- Done detection:
  - done_i is sampled into a per-channel previous-value register.
  - A rising edge with busy=1 → next cycle busy=0 and done=1.
  - A rising edge with busy=0 is ignored.
  - done_i held high has no further effect.
- W1C rules:
  - A STATUS write with bit1=1 clears done; with bit2=1 clears err.
  - If a set event and a clear hit the same cycle, set wins.
  - Writing bit0 has no effect.
- Simultaneous events:
  - A done rising edge and a start CMD in the same cycle on the same channel: busy was 1, so the start is rejected (err, pslverr).
  - Each channel is fully independent; a write to one channel never affects another.
- irq_o is registered: it reflects done & irq_en state one cycle after either changes.
- Outputs src_addr_o, dst_addr_o and len_o are direct register outputs.

Test Plan:
- Reset, then read all 6 registers of ch0..NUM_CH-1 → all read 0; irq_o=0, start_o=0.
- ch2: write SRC=0x1000_0000, DST=0x2000_0000, LEN=0x0000_12FF, then read back → LEN reads 0x0000_1280; len_o ch2 field=0x25; other channels unchanged.
- ch1: write CMD=1 → start_o=4'b0010 for one cycle, STATUS=0x1. Write CMD=1 again → no pulse, pslverr=1, STATUS=0x5. Write SRC → pslverr=1, SRC unchanged.
- ch1 busy, IRQ_EN=1: raise done_i[1] → STATUS=0x2 next cycle, irq_o=1 one cycle later. Write STATUS=0x2 → done=0, irq_o drops. Hold done_i high → no re-set.
- W1C write of done on the same cycle as a new done rising edge → done stays 1. Access paddr=0x80 with NUM_CH=4 → pslverr=1, prdata=0.
- Assert rst_n=0 asynchronously mid-run with busy=1 → busy, done, start_o and irq_o clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aidc_lite_comp_cfg_mc_if.sv
// APB target/initiator signal bundle used by the AIDC-Lite configuration blocks.
interface APB_INTF;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/aidc_lite_comp_cfg_mc.sv
// AIDC-Lite multi-channel configuration/status block: per-channel src/dst/len banks,
// start/busy tracking, sticky W1C done/err status and a combined level interrupt.
module aidc_lite_comp_cfg_mc #(
    parameter int NUM_CH  = 4,
    parameter int LEN_LSB = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    APB_INTF.slave                          apb_if,
    output logic [NUM_CH*32-1:0]            src_addr_o,
    output logic [NUM_CH*32-1:0]            dst_addr_o,
    output logic [NUM_CH*(32-LEN_LSB)-1:0]  len_o,
    output logic [NUM_CH-1:0]               start_o,
    input  logic [NUM_CH-1:0]               done_i,
    output logic                            irq_o
);
    localparam int LEN_W = 32 - LEN_LSB;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_IRQ_EN = 3'd5;

    logic [4:0]        ch;
    logic [2:0]        rsel;
    logic              addr_ok;
    logic              wr_acc;
    logic              rd_setup;
    logic [31:0]       rd_data;
    logic [31:0]       prdata_q;
    logic              slverr;
    logic              irq_q;
    logic [NUM_CH-1:0] busy_v;
    logic [NUM_CH-1:0] done_v;
    logic [NUM_CH-1:0] err_v;
    logic [NUM_CH-1:0] irq_en_v;
    logic              unused_addr;

    assign ch          = apb_if.paddr[9:5];
    assign rsel        = apb_if.paddr[4:2];
    assign addr_ok     = (int'(ch) < NUM_CH) && !(rsel[2] && rsel[1]);
    assign wr_acc      = apb_if.psel & apb_if.penable & apb_if.pwrite;
    assign rd_setup    = apb_if.psel & ~apb_if.penable & ~apb_if.pwrite;
    assign unused_addr = ^{apb_if.paddr[31:10], apb_if.paddr[1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             sel;
        logic             busy;
        logic             done;
        logic             err;
        logic             irq_en;
        logic             done_p1;
        logic             start;
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [LEN_W-1:0] len;
        logic             rise;
        logic             cmd_go;
        logic             cmd_rej;
        logic             cfg_we;
        logic             st_we;

        assign sel     = wr_acc && (ch == 5'(c));
        assign rise    = done_i[c] & ~done_p1;
        assign cmd_go  = sel && (rsel == REG_CMD) && apb_if.pwdata[0] && !busy;
        assign cmd_rej = sel && (rsel == REG_CMD) && apb_if.pwdata[0] && busy;
        assign cfg_we  = sel && !busy;
        assign st_we   = sel && (rsel == REG_STATUS);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                done_p1 <= 1'b0;
                start   <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
                err     <= 1'b0;
                irq_en  <= 1'b0;
                src     <= '0;
                dst     <= '0;
                len     <= '0;
            end else begin
                done_p1 <= done_i[c];
                start   <= cmd_go;
                if (cmd_go) begin
                    busy <= 1'b1;
                end else if (rise && busy) begin
                    busy <= 1'b0;
                end
                // A fresh set event overrides a W1C clear landing on the same edge
                done <= (done && !(st_we && apb_if.pwdata[1])) || (rise && busy);
                err  <= (err && !(st_we && apb_if.pwdata[2])) || cmd_rej;
                if (cfg_we) begin
                    case (rsel)
                        REG_SRC:    src    <= apb_if.pwdata;
                        REG_DST:    dst    <= apb_if.pwdata;
                        REG_LEN:    len    <= apb_if.pwdata[31:LEN_LSB];
                        REG_IRQ_EN: irq_en <= apb_if.pwdata[0];
                        default:    ;
                    endcase
                end
            end
        end

        assign src_addr_o[c*32 +: 32]  = src;
        assign dst_addr_o[c*32 +: 32]  = dst;
        assign len_o[c*LEN_W +: LEN_W] = len;
        assign start_o[c]              = start;
        assign busy_v[c]               = busy;
        assign done_v[c]               = done;
        assign err_v[c]                = err;
        assign irq_en_v[c]             = irq_en;
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 5'(c)) begin
                case (rsel)
                    REG_SRC:    rd_data = src_addr_o[c*32 +: 32];
                    REG_DST:    rd_data = dst_addr_o[c*32 +: 32];
                    REG_LEN:    rd_data = {len_o[c*LEN_W +: LEN_W], {LEN_LSB{1'b0}}};
                    REG_STATUS: rd_data = {29'd0, err_v[c], done_v[c], busy_v[c]};
                    REG_IRQ_EN: rd_data = {31'd0, irq_en_v[c]};
                    default:    rd_data = '0;
                endcase
            end
        end
    end

    // Busy channels reject config writes and start requests; CMD with bit0=0 is harmless
    always_comb begin
        slverr = 1'b0;
        if (!addr_ok) begin
            slverr = 1'b1;
        end else if (apb_if.pwrite) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ((ch == 5'(c)) && busy_v[c]) begin
                    case (rsel)
                        REG_SRC, REG_DST, REG_LEN, REG_IRQ_EN: slverr = 1'b1;
                        REG_CMD:                               slverr = apb_if.pwdata[0];
                        default:                               ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (rd_setup) begin
                prdata_q <= rd_data;
            end
            irq_q <= |(done_v & irq_en_v);
        end
    end

    assign apb_if.prdata  = prdata_q;
    assign apb_if.pready  = 1'b1;
    assign apb_if.pslverr = apb_if.psel & apb_if.penable & slverr;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_aidc_lite_comp_cfg_mc.sv
// Bench for aidc_lite_comp_cfg_mc: directed register scenarios plus randomized APB/done
// traffic compared against a transaction-level register model.
module tb_aidc_lite_comp_cfg_mc;
    localparam int NUM_CH  = 4;
    localparam int LEN_LSB = 7;
    localparam int LEN_W   = 32 - LEN_LSB;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_CH*32-1:0]      src_addr_o;
    logic [NUM_CH*32-1:0]      dst_addr_o;
    logic [NUM_CH*LEN_W-1:0]   len_o;
    logic [NUM_CH-1:0]         start_o;
    logic [NUM_CH-1:0]         done_i;
    logic                      irq_o;

    APB_INTF apb();

    aidc_lite_comp_cfg_mc #(.NUM_CH(NUM_CH), .LEN_LSB(LEN_LSB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apb_if     (apb),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .len_o      (len_o),
        .start_o    (start_o),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]       m_src [NUM_CH];
    logic [31:0]       m_dst [NUM_CH];
    logic [31:0]       m_len [NUM_CH];
    logic [NUM_CH-1:0] m_busy, m_done, m_err, m_ien, m_prev;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_src[c] = '0;
            m_dst[c] = '0;
            m_len[c] = '0;
        end
        m_busy = '0; m_done = '0; m_err = '0; m_ien = '0; m_prev = '0;
    endfunction

    function automatic bit addr_bad(input logic [31:0] addr);
        return (int'(addr[9:5]) >= NUM_CH) || (int'(addr[4:2]) >= 6);
    endfunction

    function automatic logic model_irq();
        return |(m_done & m_ien);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int ch;
        int r;
        ch = int'(addr[9:5]);
        r  = int'(addr[4:2]);
        if (addr_bad(addr)) return 32'd0;
        case (r)
            0:       return m_src[ch];
            1:       return m_dst[ch];
            2:       return m_len[ch];
            4:       return {29'd0, m_err[ch], m_done[ch], m_busy[ch]};
            5:       return {31'd0, m_ien[ch]};
            default: return 32'd0;
        endcase
    endfunction

    // Applies one write plus any done edges coinciding with its access edge.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [NUM_CH-1:0] rise,
                                        output bit err, output logic [NUM_CH-1:0] st);
        int ch;
        int r;
        logic [NUM_CH-1:0] busy_pre;
        ch = int'(addr[9:5]);
        r  = int'(addr[4:2]);
        busy_pre = m_busy;
        err = 1'b0;
        st  = '0;
        if (addr_bad(addr)) begin
            err = 1'b1;
        end else begin
            case (r)
                0, 1, 2, 5: begin
                    if (m_busy[ch]) err = 1'b1;
                    else if (r == 0) m_src[ch] = data;
                    else if (r == 1) m_dst[ch] = data;
                    else if (r == 2) m_len[ch] = {data[31:LEN_LSB], {LEN_LSB{1'b0}}};
                    else m_ien[ch] = data[0];
                end
                3: begin
                    if (data[0]) begin
                        if (m_busy[ch]) begin
                            err = 1'b1;
                            m_err[ch] = 1'b1;
                        end else begin
                            m_busy[ch] = 1'b1;
                            st[ch] = 1'b1;
                        end
                    end
                end
                default: begin
                    if (data[1]) m_done[ch] = 1'b0;
                    if (data[2]) m_err[ch] = 1'b0;
                end
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (rise[c] && busy_pre[c]) begin
                m_busy[c] = 1'b0;
                m_done[c] = 1'b1;
            end
        end
        m_prev = m_prev | rise;
    endfunction

    task automatic check_outputs();
        logic [NUM_CH*32-1:0]    es;
        logic [NUM_CH*32-1:0]    ed;
        logic [NUM_CH*LEN_W-1:0] el;
        for (int c = 0; c < NUM_CH; c++) begin
            es[c*32 +: 32]    = m_src[c];
            ed[c*32 +: 32]    = m_dst[c];
            el[c*LEN_W +: LEN_W] = m_len[c][31:LEN_LSB];
        end
        check("src_addr_o", src_addr_o, es);
        check("dst_addr_o", dst_addr_o, ed);
        check("len_o", len_o, el);
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [NUM_CH-1:0] rise);
        bit                exp_err;
        logic [NUM_CH-1:0] exp_start;
        model_write(addr, data, rise, exp_err, exp_start);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = addr; apb.pwdata = data;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        done_i = done_i | rise;
        #1;
        check("wr_pslverr", apb.pslverr, exp_err);
        check("wr_pready", apb.pready, 1'b1);
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        check("wr_start_pulse", start_o, exp_start);
        @(posedge clk); #1;
        check("wr_start_end", start_o, '0);
        check("wr_irq", irq_o, model_irq());
        check_outputs();
    endtask

    task automatic apb_read(input logic [31:0] addr);
        logic [31:0] exp_d;
        bit          exp_err;
        exp_d   = model_read(addr);
        exp_err = addr_bad(addr);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        #1;
        check("rd_prdata", apb.prdata, exp_d);
        check("rd_pslverr", apb.pslverr, exp_err);
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic drive_done(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] rise;
        logic              irq_before;
        rise = v & ~m_prev;
        irq_before = model_irq();
        @(posedge clk); #1;
        done_i = v;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rise[c] && m_busy[c]) begin
                m_busy[c] = 1'b0;
                m_done[c] = 1'b1;
            end
        end
        m_prev = v;
        @(posedge clk); #1;
        check("done_irq_lag", irq_o, irq_before);
        @(posedge clk); #1;
        check("done_irq", irq_o, model_irq());
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        done_i = '0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_irq", irq_o, 1'b0);
        check("rst_start", start_o, '0);
        check("rst_prdata", apb.prdata, 32'd0);
        check_outputs();
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 6; r++)
                apb_read(32'(c * 32 + r * 4));

        apb_write(32'h40, 32'h1000_0000, '0);
        apb_write(32'h44, 32'h2000_0000, '0);
        apb_write(32'h48, 32'h0000_12FF, '0);
        apb_read(32'h40);
        apb_read(32'h44);
        apb_read(32'h48);
        check("len_o_ch2", len_o[2*LEN_W +: LEN_W], 25'h25);

        apb_write(32'h34, 32'h1, '0);
        apb_write(32'h2C, 32'h1, '0);
        apb_read(32'h30);
        apb_write(32'h2C, 32'h1, '0);
        apb_read(32'h30);
        apb_write(32'h20, 32'hDEAD_BEEF, '0);
        apb_read(32'h20);

        apb_write(32'h30, 32'h4, '0);
        drive_done(4'b0010);
        apb_read(32'h30);
        apb_write(32'h30, 32'h2, '0);
        repeat (3) @(posedge clk);
        #1;
        apb_read(32'h30);

        drive_done(4'b0000);
        apb_write(32'h2C, 32'h1, '0);
        drive_done(4'b0010);
        drive_done(4'b0000);
        apb_write(32'h2C, 32'h1, '0);
        apb_write(32'h30, 32'h2, 4'b0010);
        apb_read(32'h30);

        apb_write(32'h0C, 32'h1, '0);
        apb_write(32'h0C, 32'h1, 4'b0001);
        apb_read(32'h10);

        apb_write(32'h80, 32'h1234, '0);
        apb_read(32'h80);
        apb_read(32'h18);

        apb_write(32'h14, 32'h1, '0);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 32'h4C; apb.pwdata = 32'h1;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        check("pre_rst_start", start_o, 4'b0100);
        check("pre_rst_irq", irq_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_start", start_o, '0);
        check("async_rst_irq", irq_o, 1'b0);
        check("async_rst_prdata", apb.prdata, 32'd0);
        done_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apb_read(32'h50);
        apb_read(32'h10);
        apb_read(32'h14);
        apb_read(32'h40);
        check_outputs();

        for (int i = 0; i < 300; i++) begin
            int                op;
            logic [31:0]       a;
            logic [NUM_CH-1:0] v;
            op = int'($urandom_range(0, 9));
            a  = {22'd0, 5'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 2'b00};
            if (op < 4) begin
                apb_write(a, $urandom, '0);
            end else if (op < 7) begin
                apb_read(a);
            end else begin
                v = done_i;
                v[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
                drive_done(v);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
